// File: rtl/dummycpu_pkg.sv
// Traffic-generator types: FSM encoding, run modes, default widths.
package dummycpu_pkg;
  import river_cfg_pkg::*;

  localparam int DEF_ADDR_BITS = CFG_ADDR_BITS;
  localparam int DEF_DATA_BITS = CFG_DATA_BITS;
  localparam int DEF_CNT_BITS  = CFG_CNT_BITS;

  localparam logic [1:0] MODE_WR    = 2'd0;
  localparam logic [1:0] MODE_RD    = 2'd1;
  localparam logic [1:0] MODE_WRCHK = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_DONE
  } tgen_state_e;

  // Modes 2 and 3 both follow the write phase with a verify pass.
  function automatic logic mode_has_verify(input logic [1:0] mode);
    return mode[1];
  endfunction
endpackage

// File: rtl/river_cfg_pkg.sv
// Platform-wide default widths shared by bus masters.
package river_cfg_pkg;
  localparam int CFG_ADDR_BITS = 48;
  localparam int CFG_DATA_BITS = 64;
  localparam int CFG_CNT_BITS  = 16;
endpackage

// File: rtl/dummycpu_tgen_pattern.sv
// Combinational word generator: data = seed + idx, addr = base + idx*bytes.
module dummycpu_tgen_pattern
  import dummycpu_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int CNT_BITS  = DEF_CNT_BITS
) (
  input  logic [DATA_BITS-1:0] i_seed,
  input  logic [ADDR_BITS-1:0] i_base,
  input  logic [CNT_BITS-1:0]  i_idx,
  output logic [DATA_BITS-1:0] o_data,
  output logic [ADDR_BITS-1:0] o_addr
);
  localparam int BSH = $clog2(DATA_BITS / 8);

  logic [DATA_BITS-1:0] w_idx_d;
  logic [ADDR_BITS-1:0] w_idx_a;

  // Both sums wrap at their own width; the idx is zero-extended first.
  always_comb begin
    w_idx_d = DATA_BITS'(i_idx);
    w_idx_a = ADDR_BITS'(i_idx);
    o_data  = i_seed + w_idx_d;
    o_addr  = i_base + (w_idx_a << BSH);
  end
endmodule

// File: rtl/dummycpu_tgen.sv
// Single-outstanding bus traffic generator: write, read or write-then-verify runs.
module dummycpu_tgen
  import dummycpu_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int CNT_BITS  = DEF_CNT_BITS
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [1:0]             i_mode,
  input  logic [ADDR_BITS-1:0]   i_base_addr,
  input  logic [CNT_BITS-1:0]    i_words,
  input  logic [DATA_BITS-1:0]   i_seed,
  output logic                   o_req_valid,
  input  logic                   i_req_ready,
  output logic                   o_req_write,
  output logic [ADDR_BITS-1:0]   o_req_addr,
  output logic [DATA_BITS-1:0]   o_req_wdata,
  output logic [DATA_BITS/8-1:0] o_req_wstrb,
  input  logic                   i_resp_valid,
  output logic                   o_resp_ready,
  input  logic [DATA_BITS-1:0]   i_resp_rdata,
  input  logic                   i_resp_err,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [CNT_BITS-1:0]    o_err_cnt,
  output logic [ADDR_BITS-1:0]   o_first_err_addr
);
  localparam int BSH = $clog2(DATA_BITS / 8);
  localparam logic [ADDR_BITS-1:0] ALIGN_MASK = ~ADDR_BITS'((64'd1 << BSH) - 64'd1);

  tgen_state_e r_state, w_state_nxt;

  logic [1:0]           r_mode;
  logic [ADDR_BITS-1:0] r_base;
  logic [DATA_BITS-1:0] r_seed;
  logic [CNT_BITS-1:0]  r_words;
  logic [CNT_BITS-1:0]  r_idx;
  logic                 r_write;
  logic [CNT_BITS-1:0]  r_err_cnt;
  logic [ADDR_BITS-1:0] r_first_err_addr;

  logic [DATA_BITS-1:0] w_pat_data;
  logic [ADDR_BITS-1:0] w_pat_addr;
  logic                 w_start;
  logic                 w_req_fire;
  logic                 w_resp_fire;
  logic                 w_last;
  logic                 w_err_evt;

  // One pattern unit serves both the write data and the read-compare value;
  // idx does not move between a REQ state and its RESP state.
  dummycpu_tgen_pattern #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS),
    .CNT_BITS  (CNT_BITS)
  ) u_pattern (
    .i_seed (r_seed),
    .i_base (r_base),
    .i_idx  (r_idx),
    .o_data (w_pat_data),
    .o_addr (w_pat_addr)
  );

  // Handshake decode; all outputs derive from flops only.
  always_comb begin
    o_req_valid      = (r_state == ST_WR_REQ) || (r_state == ST_RD_REQ);
    o_resp_ready     = (r_state == ST_WR_RESP) || (r_state == ST_RD_RESP);
    o_busy           = (r_state != ST_IDLE);
    o_done           = (r_state == ST_DONE);
    o_req_write      = r_write;
    o_req_addr       = w_pat_addr;
    o_req_wdata      = w_pat_data;
    o_req_wstrb      = {(DATA_BITS/8){r_write}};
    o_err_cnt        = r_err_cnt;
    o_first_err_addr = r_first_err_addr;
    w_start          = (r_state == ST_IDLE) && i_start;
    w_req_fire       = o_req_valid && i_req_ready;
    w_resp_fire      = o_resp_ready && i_resp_valid;
    w_last           = (r_idx == r_words - CNT_BITS'(1));
    w_err_evt        = w_resp_fire &&
                       (i_resp_err || ((r_state == ST_RD_RESP) && (i_resp_rdata != w_pat_data)));
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (i_words == '0)          w_state_nxt = ST_DONE;
          else if (i_mode == MODE_RD) w_state_nxt = ST_RD_REQ;
          else                        w_state_nxt = ST_WR_REQ;
        end
      end
      ST_WR_REQ:  if (w_req_fire) w_state_nxt = ST_WR_RESP;
      ST_WR_RESP: begin
        if (w_resp_fire) begin
          if (!w_last)                     w_state_nxt = ST_WR_REQ;
          else if (mode_has_verify(r_mode)) w_state_nxt = ST_RD_REQ;
          else                             w_state_nxt = ST_DONE;
        end
      end
      ST_RD_REQ:  if (w_req_fire) w_state_nxt = ST_RD_RESP;
      ST_RD_RESP: begin
        if (w_resp_fire) begin
          if (!w_last) w_state_nxt = ST_RD_REQ;
          else         w_state_nxt = ST_DONE;
        end
      end
      ST_DONE:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Run parameters, word index and write/read phase flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode  <= '0;
      r_base  <= '0;
      r_seed  <= '0;
      r_words <= '0;
      r_idx   <= '0;
      r_write <= 1'b0;
    end else if (w_start) begin
      r_mode  <= i_mode;
      r_base  <= i_base_addr & ALIGN_MASK;
      r_seed  <= i_seed;
      r_words <= i_words;
      r_idx   <= '0;
      r_write <= (i_mode != MODE_RD);
    end else if (w_resp_fire) begin
      if (!w_last) begin
        r_idx <= r_idx + CNT_BITS'(1);
      end else if ((r_state == ST_WR_RESP) && mode_has_verify(r_mode)) begin
        r_idx   <= '0;
        r_write <= 1'b0;
      end
    end
  end

  // Error accounting: saturating count, address of the first failing word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err_cnt        <= '0;
      r_first_err_addr <= '0;
    end else if (w_start) begin
      r_err_cnt        <= '0;
      r_first_err_addr <= '0;
    end else if (w_err_evt) begin
      if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_BITS'(1);
      if (r_err_cnt == '0) r_first_err_addr <= w_pat_addr;
    end
  end
endmodule

// File: tb/tb_dummycpu_tgen.sv
// Directed bench for dummycpu_tgen with a small ideal memory model.
module tb_dummycpu_tgen;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [47:0] base;
  logic [15:0] words;
  logic [63:0] seed;
  logic        req_valid, req_ready, req_write;
  logic [47:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic        busy, done;
  logic [15:0] err_cnt;
  logic [47:0] first_err;

  logic        resp_en, force_rv, force_err, corrupt, valid_seen;
  logic [47:0] corrupt_addr;
  logic [63:0] mem [16];
  logic [47:0] wr_q[$];
  logic [47:0] rd_q[$];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dummycpu_tgen dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode),
    .i_base_addr(base), .i_words(words), .i_seed(seed),
    .o_req_valid(req_valid), .i_req_ready(req_ready), .o_req_write(req_write),
    .o_req_addr(req_addr), .o_req_wdata(req_wdata), .o_req_wstrb(req_wstrb),
    .i_resp_valid(resp_valid), .o_resp_ready(resp_ready),
    .i_resp_rdata(resp_rdata), .i_resp_err(resp_err),
    .o_busy(busy), .o_done(done), .o_err_cnt(err_cnt),
    .o_first_err_addr(first_err)
  );

  // Zero-wait responder; read data comes straight from the memory model.
  always_comb begin
    resp_valid = (resp_en && resp_ready) || force_rv;
    resp_err   = force_err;
    resp_rdata = mem[req_addr[6:3]] ^
                 ((corrupt && req_addr == corrupt_addr) ? 64'd1 : 64'd0);
  end

  always @(posedge clk) begin
    if (req_valid) valid_seen = 1'b1;
    if (!rst && req_valid && req_ready) begin
      if (req_write) begin
        mem[req_addr[6:3]] <= req_wdata;
        wr_q.push_back(req_addr);
      end else begin
        rd_q.push_back(req_addr);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic go(input logic [1:0] m, input logic [47:0] b,
                    input logic [15:0] w, input logic [63:0] s);
    wr_q.delete(); rd_q.delete();
    mode = m; base = b; words = w; seed = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts cycles from the first post-start cycle until o_done is seen.
  task automatic run_to_done(output int n);
    n = 0;
    while (!done && n < 300) begin
      n++;
      tick();
    end
    if (!done) chk("timeout_done", 64'd0, 64'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; mode = 2'd0; base = '0; words = '0; seed = '0;
    req_ready = 1'b1; resp_en = 1'b1; force_rv = 1'b0; force_err = 1'b0;
    corrupt = 1'b0; corrupt_addr = '0; valid_seen = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_valid", 64'(req_valid), 64'd0);
    chk("rst_addr",  64'(req_addr), 64'd0);
    chk("rst_wdata", req_wdata, 64'd0);
    chk("rst_wstrb", 64'(req_wstrb), 64'd0);
    chk("rst_rready", 64'(resp_ready), 64'd0);
    chk("rst_done",  64'(done), 64'd0);
    chk("rst_errs",  64'(err_cnt), 64'd0);
    chk("rst_ferr",  64'(first_err), 64'd0);

    // Write-then-verify, 4 words, ideal memory
    go(2'd2, 48'h1000, 16'd4, 64'hA5);
    run_to_done(n);
    chk("wv4_cycles", 64'(n), 64'd16);
    chk("wv4_nwr", 64'(wr_q.size()), 64'd4);
    chk("wv4_nrd", 64'(rd_q.size()), 64'd4);
    chk("wv4_wa3", 64'(wr_q[3]), 64'h1018);
    chk("wv4_ra0", 64'(rd_q[0]), 64'h1000);
    chk("wv4_m0", mem[0], 64'hA5);
    chk("wv4_m3", mem[3], 64'hA8);
    chk("wv4_errs", 64'(err_cnt), 64'd0);
    tick();
    chk("wv4_done_pulse", 64'(done), 64'd0);
    chk("wv4_idle", 64'(busy), 64'd0);

    // Verify with a corrupted word at 0x1008
    corrupt = 1'b1; corrupt_addr = 48'h1008;
    go(2'd2, 48'h1000, 16'd3, 64'h10);
    run_to_done(n);
    chk("corr_errs", 64'(err_cnt), 64'd1);
    chk("corr_ferr", 64'(first_err), 64'h1008);
    corrupt = 1'b0;
    tick();
    chk("corr_hold", 64'(err_cnt), 64'd1);

    // Read-only against stale contents: words 0..2 mismatch, word 3 matches
    go(2'd1, 48'h1000, 16'd4, 64'hA5);
    run_to_done(n);
    chk("ro_cycles", 64'(n), 64'd8);
    chk("ro_nwr", 64'(wr_q.size()), 64'd0);
    chk("ro_errs", 64'(err_cnt), 64'd3);
    chk("ro_ferr", 64'(first_err), 64'h1000);
    tick();

    // Write-only with ready held low; base misaligned; a start while busy is ignored
    req_ready = 1'b0;
    go(2'd0, 48'h2005, 16'd2, 64'h55);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 64'(req_valid), 64'd1);
      chk("stall_addr",  64'(req_addr), 64'h2000);
      chk("stall_wdata", req_wdata, 64'h55);
      chk("stall_write", 64'(req_write), 64'd1);
      chk("stall_wstrb", 64'(req_wstrb), 64'hFF);
      start = (i == 2); mode = 2'd1; base = 48'h0;
      tick();
    end
    start = 1'b0;
    req_ready = 1'b1;
    run_to_done(n);
    chk("stall_nwr", 64'(wr_q.size()), 64'd2);
    chk("stall_nrd", 64'(rd_q.size()), 64'd0);
    chk("stall_wa1", 64'(wr_q[1]), 64'h2008);
    tick();

    // Zero-word run
    valid_seen = 1'b0;
    go(2'd2, 48'h1000, 16'd0, 64'h1);
    chk("w0_done", 64'(done), 64'd1);
    tick();
    chk("w0_after", 64'(done), 64'd0);
    chk("w0_idle", 64'(busy), 64'd0);
    chk("w0_novalid", 64'(valid_seen), 64'd0);

    // Reset in WR_RESP, stale response afterwards, then a clean run
    resp_en = 1'b0;
    go(2'd2, 48'h1000, 16'd2, 64'h30);
    tick();
    chk("mr_in_resp", 64'(resp_ready), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_valid", 64'(req_valid), 64'd0);
    force_rv = 1'b1; force_err = 1'b1;
    tick(); tick();
    force_rv = 1'b0; force_err = 1'b0;
    chk("mr_stale_busy", 64'(busy), 64'd0);
    chk("mr_stale_errs", 64'(err_cnt), 64'd0);
    resp_en = 1'b1;
    go(2'd2, 48'h1000, 16'd2, 64'h30);
    run_to_done(n);
    chk("mr_rerun_cycles", 64'(n), 64'd8);
    chk("mr_rerun_errs", 64'(err_cnt), 64'd0);
    tick();

    // Bus error flag on every write response
    force_err = 1'b1;
    go(2'd0, 48'h1040, 16'd2, 64'h7);
    run_to_done(n);
    force_err = 1'b0;
    chk("berr_errs", 64'(err_cnt), 64'd2);
    chk("berr_ferr", 64'(first_err), 64'h1040);
    tick();

    // Address wrap at 2^48
    go(2'd0, 48'hFFFF_FFFF_FFF8, 16'd2, 64'h0);
    run_to_done(n);
    chk("wrap_a0", 64'(wr_q[0]), 64'hFFFF_FFFF_FFF8);
    chk("wrap_a1", 64'(wr_q[1]), 64'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
